// File: rtl/mem_wait_ctrl_if.sv
`default_nettype none
// +-------------------------------------------------------------+
// | mem_wait_ctrl_if: core memory-port bundle (req in, resp out) |
// | Rev 1.0                                                      |
// +-------------------------------------------------------------+
interface mem_wait_ctrl_if;
  logic        req_rd;
  logic        req_wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        err;

  modport master (
    output req_rd, req_wr, addr, wdata,
    input  rdata, ready, busy, err
  );

  modport slave (
    input  req_rd, req_wr, addr, wdata,
    output rdata, ready, busy, err
  );
endinterface
`default_nettype wire

// File: rtl/mem_wait_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | mem_wait_ctrl: wait-state controller owning the word-addressed RAM |
// | Option MEM_ALIGN_CHECK_EN rejects misaligned addresses. Rev 1.0    |
// +-------------------------------------------------------------------+
module mem_wait_ctrl #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  wire logic       clk,
  input  wire logic       rst,
  mem_wait_ctrl_if.slave  bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (WAIT_CYCLES > 15) begin : g_wait_range
    $error("mem_wait_ctrl: WAIT_CYCLES must be 0..15");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [3:0]        cnt;
  logic              op_wr;
  logic              err_flag;
  logic [IDX_W-1:0]  idx;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [31:0]       ram [DEPTH];

  logic [29:0]       word_idx;
  logic              req_any;
  logic              req_err;
  logic              accept;
  logic              commit;
  logic              ready_c;
  logic              busy_c;
  logic              err_c;

  assign word_idx = bus.addr[31:2];
  assign req_any  = bus.req_rd | bus.req_wr;

`ifdef MEM_ALIGN_CHECK_EN
  assign req_err = (bus.req_rd & bus.req_wr)
                 | ({2'b00, word_idx} >= 32'(DEPTH))
                 | (bus.addr[1:0] != 2'b00);
`else
  // Byte offset is ignored; the access lands on the containing word.
  logic unused_low_bits;
  assign unused_low_bits = ^bus.addr[1:0];
  assign req_err = (bus.req_rd & bus.req_wr)
                 | ({2'b00, word_idx} >= 32'(DEPTH));
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    commit     = 1'b0;
    busy_c     = (state != IDLE);
    ready_c    = (state == DONE);
    err_c      = (state == DONE) & err_flag;
    case (state)
      IDLE: begin
        if (req_any) begin
          accept     = 1'b1;
          next_state = req_err ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          commit     = 1'b1;
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= 4'd0;
      op_wr    <= 1'b0;
      err_flag <= 1'b0;
      idx      <= '0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
    end else begin
      if (accept) begin
        cnt      <= 4'(WAIT_CYCLES);
        op_wr    <= bus.req_wr;
        err_flag <= req_err;
        idx      <= bus.addr[IDX_W+1:2];
        wdata_q  <= bus.wdata;
      end else if ((state == WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (commit && !op_wr) rdata_q <= ram[idx];
    end
  end

  // RAM survives reset; a pending write is dropped because reset forces IDLE.
  always_ff @(posedge clk) begin
    if (commit && op_wr) ram[idx] <= wdata_q;
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = ready_c;
  assign bus.busy  = busy_c;
  assign bus.err   = err_c;

endmodule
`default_nettype wire

// File: doc/mem_wait_ctrl.md
# mem_wait_ctrl

Wait-state memory controller between the multicycle processor core and its unified instruction/data RAM. It accepts single-word read/write requests from the core's memory port, holds them for a configurable number of wait states, and returns read data with a one-cycle `ready` pulse. It also exposes `busy` so the control unit can stall its state machine. It owns the word-addressed RAM array, so the core sees a variable-latency memory instead of a combinational one.

## Interface
- `DEPTH`, 256: RAM size in 32-bit words; word index is `addr[31:2]`.
- `WAIT_CYCLES`, 2: wait states inserted per access (0..15).
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_rd`  in  1  read request, from core MemRead.
- `req_wr`  in  1  write request, from core MemWrite.
- `addr`  in  32  byte address, from the IorD address mux.
- `wdata`  in  32  write data, core register B.
- `rdata`  out  32  read data, held until the next successful read completes.
- `ready`  out  1  one-cycle completion pulse.
- `busy`  out  1  access in progress; core must stall.
- `err`  out  1  one-cycle error pulse, coincident with `ready`.

## Operation
- Three states: IDLE, WAIT, DONE.
- IDLE:
  - Requests are sampled only here.
  - If `req_rd` or `req_wr` is high at a rising edge, latch `addr`, `wdata` and op, and load `cnt <= WAIT_CYCLES`.
  - Go to WAIT, or straight to DONE with error (see below).
- WAIT:
  - Each edge: if `cnt == 0`, go to DONE and commit the access; else `cnt <= cnt - 1`.
  - Commit for a read: `rdata <= ram[idx]`. Commit for a write: `ram[idx] <= wdata_latched`.
- DONE:
  - `ready = 1` for exactly this cycle. Next edge returns to IDLE unconditionally.
  - No request is accepted in DONE.
  - The core must deassert its request in the cycle where `ready` is high, otherwise a level-held request is re-accepted in IDLE.
- Error cases. Each goes IDLE→DONE directly with `err = 1` and `ready = 1`, no RAM access, and `rdata` unchanged:
  - `req_rd && req_wr` both high.
  - Word index `>= DEPTH`.
  - Misaligned address (see Configuration).
- `busy` is high in WAIT and DONE, low in IDLE.
- Request inputs are ignored while `busy` is high; latched values are not disturbed.
- `cnt` is 4 bits wide. `WAIT_CYCLES > 15` is illegal and triggers a simulation `$error` at elaboration.

## Timing
- Reset values:
  - `rdata = 0`, `ready = 0`, `busy = 0`, `err = 0`, state IDLE, `cnt = 0`.
  - RAM contents are not affected by `rst`.
- Request accepted at edge E0. Commit at edge E(W+1), where W = `WAIT_CYCLES`.
- `ready` and new `rdata` are visible in the cycle after E(W+1).
- Return to IDLE at E(W+2). Earliest next accept is E(W+3).
- W = 0: `ready` is visible in the cycle after E1.
- Error requests: `ready`/`err` are visible in the cycle after E0, IDLE again at E1.
- Reset asserted mid-access:
  - Immediate return to IDLE and all outputs drop to reset values.
  - A write that has not yet reached its commit edge is discarded; RAM is unchanged.
- Back-to-back access throughput is one access per W+3 cycles.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - Any request with `addr[1:0] != 2'b00` is an error (err path above).
- Undefined:
  - `addr[1:0]` is ignored and the access proceeds to word `addr[31:2]`.
  - `err` is raised only for the both-requests and out-of-range cases.

## Test plan
- Reset, then write `0xDEADBEEF` to `addr 0x10` with W = 2: `busy` high for 4 cycles, `ready` pulses once at the cycle after E3, `err = 0`. Then read `0x10`: `rdata = 0xDEADBEEF` when `ready` is high.
- Same write/read sequence with W = 0: `ready` is visible in the cycle after E1, and `rdata` is correct.
- `req_rd = req_wr = 1` at `addr 0x20`: `ready = err = 1` in the cycle after E0, `rdata` unchanged, `ram[8]` unchanged.
- Read `addr = DEPTH*4` (`0x400`): error pulse, `rdata` retains its previous value.
- `addr 0x13` read after writing `0x12345678` to `0x10`:
  - With `MEM_ALIGN_CHECK_EN`: `err = 1` and `rdata` unchanged.
  - Without it: `rdata = 0x12345678`, `err = 0`.
- Write `0xCAFEF00D` to `0x30` with W = 3, assert `rst` low at E2 for one cycle: outputs are 0 and state is IDLE. A subsequent read of `0x30` returns the old contents (0 after a zeroed preload).
